// File: rtl/nh_lcd_pkg.sv
// Shared opcodes, FSM state encoding and read-back helper for the LCD responder.
package nh_lcd_pkg;

    localparam logic [7:0] CMD_READ_ID   = 8'h04;
    localparam logic [7:0] CMD_COL_ADDR  = 8'h2A;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h2B;
    localparam logic [7:0] CMD_MEM_WRITE = 8'h2C;
    localparam logic [7:0] CMD_TE_OFF    = 8'h34;
    localparam logic [7:0] CMD_TE_ON     = 8'h35;
    localparam logic [7:0] CMD_MEM_CONT  = 8'h3C;

    // Read index stops here; anything at or beyond it reads back as zero.
    localparam logic [2:0] READ_IDX_MAX  = 3'd4;

    // Parameter bytes beyond the fourth in an address window are ignored.
    localparam logic [2:0] ADDR_IDX_MAX  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MEM_WRITE = 3'd1,
        ST_COL_ADDR  = 3'd2,
        ST_PAGE_ADDR = 3'd3,
        ST_READ_ID   = 3'd4
    } lcd_state_t;

    // Byte returned by the read-ID sequence: a dummy byte, then the 3 ID bytes.
    function automatic logic [7:0] read_id_byte(input logic [2:0] idx, input logic [23:0] id);
        logic [7:0] b;
        case (idx)
            3'd1:    b = id[23:16];
            3'd2:    b = id[15:8];
            3'd3:    b = id[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nh_lcd_bus_sync.sv
// Two-flop synchronizers for the host bus plus edge detection on the strobes.
module nh_lcd_bus_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       reset_n_async,
    input  logic       cs_n_async,
    input  logic       rs_async,
    input  logic       write_n_async,
    input  logic       read_n_async,
    input  logic [7:0] data_async,
    output logic       panel_reset_n,
    output logic       cs_n,
    output logic       rs,
    output logic       write_n,
    output logic       read_n,
    output logic [7:0] data,
    output logic       write_rise,
    output logic       read_fall,
    output logic       read_rise
);

    logic [1:0] reset_n_q;
    logic [1:0] cs_n_q;
    logic [1:0] rs_q;
    logic [1:0] write_n_q;
    logic [1:0] read_n_q;
    logic [7:0] data_q0;
    logic [7:0] data_q1;
    logic       write_n_d;
    logic       read_n_d;

    // Two-stage synchronizers; strobes and chip select idle high, the rest low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reset_n_q <= 2'b00;
            cs_n_q    <= 2'b11;
            rs_q      <= 2'b00;
            write_n_q <= 2'b11;
            read_n_q  <= 2'b11;
            data_q0   <= 8'h00;
            data_q1   <= 8'h00;
        end else begin
            reset_n_q <= {reset_n_q[0], reset_n_async};
            cs_n_q    <= {cs_n_q[0], cs_n_async};
            rs_q      <= {rs_q[0], rs_async};
            write_n_q <= {write_n_q[0], write_n_async};
            read_n_q  <= {read_n_q[0], read_n_async};
            data_q0   <= data_async;
            data_q1   <= data_q0;
        end
    end

    // Previous synchronized strobe levels, used to find edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_n_d <= 1'b1;
            read_n_d  <= 1'b1;
        end else begin
            write_n_d <= write_n_q[1];
            read_n_d  <= read_n_q[1];
        end
    end

    assign panel_reset_n = reset_n_q[1];
    assign cs_n          = cs_n_q[1];
    assign rs            = rs_q[1];
    assign write_n       = write_n_q[1];
    assign read_n        = read_n_q[1];
    assign data          = data_q1;

    assign write_rise = write_n_q[1] && !write_n_d;
    assign read_fall  = !read_n_q[1] && read_n_d;
    assign read_rise  = read_n_q[1] && !read_n_d;

endmodule

// File: rtl/nh_lcd_responder.sv
// Host-side LCD panel responder: command decode, pixel/address capture,
// ID read-back and tearing-effect generation.
module nh_lcd_responder
    import nh_lcd_pkg::*;
#(
    parameter logic [23:0] ID_VALUE  = 24'h7F8A3C,
    parameter logic [31:0] TE_PERIOD = 32'd1000,
    parameter logic [31:0] TE_WIDTH  = 32'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_reset_n,
    input  logic        i_cs_n,
    input  logic        i_register_data_sel,
    input  logic        i_write_n,
    input  logic        i_read_n,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_read_en,
    output logic        o_tearing_effect,
    output logic        o_cmd_stb,
    output logic [7:0]  o_cmd,
    output logic        o_param_stb,
    output logic [7:0]  o_param,
    output logic        o_pixel_stb,
    output logic [23:0] o_pixel,
    output logic [31:0] o_pixel_count,
    output logic [15:0] o_col_start,
    output logic [15:0] o_col_end,
    output logic [15:0] o_page_start,
    output logic [15:0] o_page_end,
    output logic        o_bus_error
);

    logic       panel_reset_n;
    logic       cs_n_s;
    logic       rs_s;
    logic       write_n_s;
    logic       read_n_s;
    logic [7:0] data_s;
    logic       write_rise;
    logic       read_fall;
    logic       read_rise;

    lcd_state_t state;
    lcd_state_t next_state;

    logic        te_en;
    logic [31:0] te_cnt;
    logic [2:0]  byte_idx;
    logic [2:0]  read_idx;
    logic [7:0]  addr_hi;
    logic        wr_kill;
    logic        rd_kill;

    logic soft_reset;
    logic conflict;
    logic wr_accept;
    logic cmd_accept;
    logic data_accept;
    logic rd_start;
    logic te_set;
    logic te_clr;
    logic count_clear;

    nh_lcd_bus_sync u_bus_sync (
        .clk           (clk),
        .rst           (rst),
        .reset_n_async (i_reset_n),
        .cs_n_async    (i_cs_n),
        .rs_async      (i_register_data_sel),
        .write_n_async (i_write_n),
        .read_n_async  (i_read_n),
        .data_async    (i_data),
        .panel_reset_n (panel_reset_n),
        .cs_n          (cs_n_s),
        .rs            (rs_s),
        .write_n       (write_n_s),
        .read_n        (read_n_s),
        .data          (data_s),
        .write_rise    (write_rise),
        .read_fall     (read_fall),
        .read_rise     (read_rise)
    );

    // A simultaneous write and read is a protocol violation; both are dropped.
    assign soft_reset  = !panel_reset_n;
    assign conflict    = !write_n_s && !read_n_s && !cs_n_s;
    assign wr_accept   = write_rise && !cs_n_s && !wr_kill;
    assign cmd_accept  = wr_accept && !rs_s;
    assign data_accept = wr_accept && rs_s;
    assign rd_start    = read_fall && !cs_n_s && !conflict;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Command decode: any command byte redirects the FSM from any state.
    always_comb begin
        next_state  = state;
        te_set      = 1'b0;
        te_clr      = 1'b0;
        count_clear = 1'b0;
        if (cmd_accept) begin
            case (data_s)
                CMD_MEM_WRITE: begin
                    next_state  = ST_MEM_WRITE;
                    count_clear = 1'b1;
                end
                CMD_MEM_CONT:  next_state = ST_MEM_WRITE;
                CMD_COL_ADDR:  next_state = ST_COL_ADDR;
                CMD_PAGE_ADDR: next_state = ST_PAGE_ADDR;
                CMD_READ_ID:   next_state = ST_READ_ID;
                CMD_TE_ON: begin
                    next_state = ST_IDLE;
                    te_set     = 1'b1;
                end
                CMD_TE_OFF: begin
                    next_state = ST_IDLE;
                    te_clr     = 1'b1;
                end
                default:       next_state = ST_IDLE;
            endcase
        end
        if (soft_reset) begin
            next_state = ST_IDLE;
        end
    end

    // Write datapath: strobes, pixel assembly and address window capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_cmd_stb     <= 1'b0;
            o_cmd         <= 8'h00;
            o_param_stb   <= 1'b0;
            o_param       <= 8'h00;
            o_pixel_stb   <= 1'b0;
            o_pixel       <= 24'h000000;
            o_pixel_count <= 32'd0;
            o_col_start   <= 16'h0000;
            o_col_end     <= 16'h0000;
            o_page_start  <= 16'h0000;
            o_page_end    <= 16'h0000;
            byte_idx      <= 3'd0;
            addr_hi       <= 8'h00;
        end else if (soft_reset) begin
            o_cmd_stb     <= 1'b0;
            o_cmd         <= 8'h00;
            o_param_stb   <= 1'b0;
            o_param       <= 8'h00;
            o_pixel_stb   <= 1'b0;
            o_pixel       <= 24'h000000;
            o_pixel_count <= 32'd0;
            o_col_start   <= 16'h0000;
            o_col_end     <= 16'h0000;
            o_page_start  <= 16'h0000;
            o_page_end    <= 16'h0000;
            byte_idx      <= 3'd0;
            addr_hi       <= 8'h00;
        end else begin
            o_cmd_stb   <= 1'b0;
            o_param_stb <= 1'b0;
            o_pixel_stb <= 1'b0;
            if (cmd_accept) begin
                o_cmd_stb <= 1'b1;
                o_cmd     <= data_s;
                byte_idx  <= 3'd0;
                if (count_clear) begin
                    o_pixel_count <= 32'd0;
                end
            end else if (data_accept) begin
                case (state)
                    ST_MEM_WRITE: begin
                        case (byte_idx)
                            3'd0: begin
                                o_pixel[23:16] <= data_s;
                                byte_idx       <= 3'd1;
                            end
                            3'd1: begin
                                o_pixel[15:8] <= data_s;
                                byte_idx      <= 3'd2;
                            end
                            default: begin
                                o_pixel[7:0] <= data_s;
                                o_pixel_stb  <= 1'b1;
                                byte_idx     <= 3'd0;
                                if (o_pixel_count != 32'hFFFF_FFFF) begin
                                    o_pixel_count <= o_pixel_count + 32'd1;
                                end
                            end
                        endcase
                    end
                    ST_COL_ADDR, ST_PAGE_ADDR: begin
                        o_param_stb <= 1'b1;
                        o_param     <= data_s;
                        case (byte_idx)
                            3'd0, 3'd2: addr_hi <= data_s;
                            3'd1: begin
                                if (state == ST_COL_ADDR) o_col_start  <= {addr_hi, data_s};
                                else                      o_page_start <= {addr_hi, data_s};
                            end
                            3'd3: begin
                                if (state == ST_COL_ADDR) o_col_end  <= {addr_hi, data_s};
                                else                      o_page_end <= {addr_hi, data_s};
                            end
                            default: ;
                        endcase
                        if (byte_idx != ADDR_IDX_MAX) begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                    default: begin
                        o_param_stb <= 1'b1;
                        o_param     <= data_s;
                    end
                endcase
            end
        end
    end

    // Read side, conflict tracking and the sticky bus error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_read_en   <= 1'b0;
            o_data      <= 8'h00;
            read_idx    <= 3'd0;
            wr_kill     <= 1'b0;
            rd_kill     <= 1'b0;
            o_bus_error <= 1'b0;
        end else begin
            if (conflict) begin
                o_bus_error <= 1'b1;
            end
            if (soft_reset) begin
                o_read_en <= 1'b0;
                o_data    <= 8'h00;
                read_idx  <= 3'd0;
                wr_kill   <= 1'b0;
                rd_kill   <= 1'b0;
            end else begin
                if (write_rise) begin
                    wr_kill <= 1'b0;
                end
                if (conflict) begin
                    wr_kill   <= 1'b1;
                    rd_kill   <= 1'b1;
                    o_read_en <= 1'b0;
                end else if (rd_start) begin
                    o_read_en <= 1'b1;
                    o_data    <= (state == ST_READ_ID) ? read_id_byte(read_idx, ID_VALUE) : 8'h00;
                end else if (read_rise) begin
                    if (rd_kill) begin
                        rd_kill <= 1'b0;
                    end else if (o_read_en) begin
                        o_read_en <= 1'b0;
                        if (read_idx != READ_IDX_MAX) begin
                            read_idx <= read_idx + 3'd1;
                        end
                    end
                end
                if (cmd_accept && (data_s == CMD_READ_ID)) begin
                    read_idx <= 3'd0;
                end
            end
        end
    end

    // Tearing-effect counter, free-running only while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            te_en  <= 1'b0;
            te_cnt <= 32'd0;
        end else if (soft_reset) begin
            te_en  <= 1'b0;
            te_cnt <= 32'd0;
        end else begin
            if (te_clr) begin
                te_en  <= 1'b0;
                te_cnt <= 32'd0;
            end else if (te_set && !te_en) begin
                te_en  <= 1'b1;
                te_cnt <= 32'd0;
            end else if (te_en) begin
                te_cnt <= (te_cnt >= TE_PERIOD - 32'd1) ? 32'd0 : te_cnt + 32'd1;
            end
        end
    end

    assign o_tearing_effect = te_en && (te_cnt < TE_WIDTH);

endmodule

// File: tb/tb_nh_lcd_responder.sv
// Directed self-checking bench for nh_lcd_responder.
module tb_nh_lcd_responder;

    logic        clk;
    logic        rst;
    logic        i_reset_n;
    logic        i_cs_n;
    logic        i_register_data_sel;
    logic        i_write_n;
    logic        i_read_n;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        o_read_en;
    logic        o_tearing_effect;
    logic        o_cmd_stb;
    logic [7:0]  o_cmd;
    logic        o_param_stb;
    logic [7:0]  o_param;
    logic        o_pixel_stb;
    logic [23:0] o_pixel;
    logic [31:0] o_pixel_count;
    logic [15:0] o_col_start;
    logic [15:0] o_col_end;
    logic [15:0] o_page_start;
    logic [15:0] o_page_end;
    logic        o_bus_error;

    int checks   = 0;
    int failures = 0;

    int          cmd_pulses   = 0;
    int          param_pulses = 0;
    int          pixel_pulses = 0;
    int          te_high      = 0;
    logic [23:0] last_pixel   = 24'h0;

    nh_lcd_responder #(
        .ID_VALUE  (24'h7F8A3C),
        .TE_PERIOD (32'd20),
        .TE_WIDTH  (32'd3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_reset_n           (i_reset_n),
        .i_cs_n              (i_cs_n),
        .i_register_data_sel (i_register_data_sel),
        .i_write_n           (i_write_n),
        .i_read_n            (i_read_n),
        .i_data              (i_data),
        .o_data              (o_data),
        .o_read_en           (o_read_en),
        .o_tearing_effect    (o_tearing_effect),
        .o_cmd_stb           (o_cmd_stb),
        .o_cmd               (o_cmd),
        .o_param_stb         (o_param_stb),
        .o_param             (o_param),
        .o_pixel_stb         (o_pixel_stb),
        .o_pixel             (o_pixel),
        .o_pixel_count       (o_pixel_count),
        .o_col_start         (o_col_start),
        .o_col_end           (o_col_end),
        .o_page_start        (o_page_start),
        .o_page_end          (o_page_end),
        .o_bus_error         (o_bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse and TE counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (o_cmd_stb) cmd_pulses++;
        if (o_param_stb) param_pulses++;
        if (o_pixel_stb) begin
            pixel_pulses++;
            last_pixel = o_pixel;
        end
        if (o_tearing_effect) te_high++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One complete host write cycle: rs=0 command, rs=1 data.
    task automatic applyStimulus(input logic rs, input logic [7:0] value);
        @(posedge clk); #1;
        i_cs_n              = 1'b0;
        i_register_data_sel = rs;
        i_data              = value;
        i_write_n           = 1'b0;
        repeat (3) @(posedge clk); #1;
        i_write_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        i_cs_n = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    // One host read cycle, returning bus data and enable during and after.
    task automatic readByte(output logic [7:0] value, output logic en_during, output logic en_after);
        @(posedge clk); #1;
        i_cs_n   = 1'b0;
        i_read_n = 1'b0;
        repeat (4) @(posedge clk); #1;
        value     = o_data;
        en_during = o_read_en;
        i_read_n  = 1'b1;
        repeat (4) @(posedge clk); #1;
        en_after = o_read_en;
        i_cs_n   = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] rd_value;
        logic       rd_en_during;
        logic       rd_en_after;
        logic [7:0] id_expect [5];
        int         snap_a;
        int         snap_b;
        int         snap_c;

        id_expect[0] = 8'h00;
        id_expect[1] = 8'h7F;
        id_expect[2] = 8'h8A;
        id_expect[3] = 8'h3C;
        id_expect[4] = 8'h00;

        rst                 = 1'b0;
        i_reset_n           = 1'b1;
        i_cs_n              = 1'b1;
        i_register_data_sel = 1'b0;
        i_write_n           = 1'b1;
        i_read_n            = 1'b1;
        i_data              = 8'h00;

        // Reset state
        #1;
        checkOutput("rst_read_en", {31'd0, o_read_en}, 32'd0);
        checkOutput("rst_pixel_count", o_pixel_count, 32'd0);
        checkOutput("rst_bus_error", {31'd0, o_bus_error}, 32'd0);
        checkOutput("rst_te", {31'd0, o_tearing_effect}, 32'd0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) @(posedge clk); #1;

        // Strobe latency: exactly three clocks after write_n rises
        i_cs_n              = 1'b0;
        i_register_data_sel = 1'b0;
        i_data              = 8'h2C;
        i_write_n           = 1'b0;
        repeat (3) @(posedge clk); #1;
        i_write_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        checkOutput("cmd_stb_early", {31'd0, o_cmd_stb}, 32'd0);
        @(posedge clk); #1;
        checkOutput("cmd_stb_at3", {31'd0, o_cmd_stb}, 32'd1);
        checkOutput("cmd_value", {24'd0, o_cmd}, 32'h2C);
        @(posedge clk); #1;
        checkOutput("cmd_stb_width", {31'd0, o_cmd_stb}, 32'd0);
        i_cs_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Pixel assembly: four bytes give one pixel and a dangling byte
        snap_a = pixel_pulses;
        snap_b = param_pulses;
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);
        applyStimulus(1'b1, 8'h33);
        applyStimulus(1'b1, 8'h44);
        checkOutput("pixel_pulses", pixel_pulses - snap_a, 32'd1);
        checkOutput("pixel_value", {8'd0, last_pixel}, 32'h112233);
        checkOutput("pixel_count", o_pixel_count, 32'd1);
        checkOutput("pixel_no_param", param_pulses - snap_b, 32'd0);

        // Column window plus an extra ignored byte
        snap_b = param_pulses;
        applyStimulus(1'b0, 8'h2A);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h10);
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h3F);
        checkOutput("col_start", {16'd0, o_col_start}, 32'h0010);
        checkOutput("col_end", {16'd0, o_col_end}, 32'h013F);
        checkOutput("col_param_pulses", param_pulses - snap_b, 32'd4);
        applyStimulus(1'b1, 8'h55);
        checkOutput("col_end_extra", {16'd0, o_col_end}, 32'h013F);
        checkOutput("col_param_extra", param_pulses - snap_b, 32'd5);

        // Page window
        applyStimulus(1'b0, 8'h2B);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hEF);
        checkOutput("page_start", {16'd0, o_page_start}, 32'h0002);
        checkOutput("page_end", {16'd0, o_page_end}, 32'h00EF);

        // ID read-back, saturating after the last ID byte
        applyStimulus(1'b0, 8'h04);
        for (int i = 0; i < 5; i++) begin
            readByte(rd_value, rd_en_during, rd_en_after);
            checkOutput($sformatf("id_byte%0d", i), {24'd0, rd_value}, {24'd0, id_expect[i]});
            checkOutput($sformatf("id_en_during%0d", i), {31'd0, rd_en_during}, 32'd1);
            checkOutput($sformatf("id_en_after%0d", i), {31'd0, rd_en_after}, 32'd0);
        end

        // Tearing effect: 3 high cycles per 20 while enabled
        applyStimulus(1'b0, 8'h35);
        snap_c = te_high;
        repeat (40) @(posedge clk); #1;
        checkOutput("te_high_40", te_high - snap_c, 32'd6);
        snap_c = te_high;
        repeat (20) @(posedge clk); #1;
        checkOutput("te_high_20", te_high - snap_c, 32'd3);
        applyStimulus(1'b0, 8'h34);
        snap_c = te_high;
        repeat (40) @(posedge clk); #1;
        checkOutput("te_off", te_high - snap_c, 32'd0);

        // Continue-write keeps the pixel count
        applyStimulus(1'b0, 8'h3C);
        applyStimulus(1'b1, 8'hA1);
        applyStimulus(1'b1, 8'hB2);
        applyStimulus(1'b1, 8'hC3);
        checkOutput("cont_count", o_pixel_count, 32'd2);
        checkOutput("cont_pixel", {8'd0, o_pixel}, 32'hA1B2C3);

        // Simultaneous write and read: error flagged, nothing accepted
        snap_a = cmd_pulses + param_pulses + pixel_pulses;
        @(posedge clk); #1;
        i_cs_n              = 1'b0;
        i_register_data_sel = 1'b1;
        i_data              = 8'h99;
        i_write_n           = 1'b0;
        i_read_n            = 1'b0;
        repeat (4) @(posedge clk); #1;
        checkOutput("err_read_en_low", {31'd0, o_read_en}, 32'd0);
        i_write_n = 1'b1;
        i_read_n  = 1'b1;
        repeat (5) @(posedge clk); #1;
        i_cs_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        checkOutput("err_flag", {31'd0, o_bus_error}, 32'd1);
        checkOutput("err_no_strobes", cmd_pulses + param_pulses + pixel_pulses - snap_a, 32'd0);
        checkOutput("err_count_kept", o_pixel_count, 32'd2);

        // Panel reset pulse: state cleared, error flag kept
        i_reset_n = 1'b0;
        repeat (5) @(posedge clk); #1;
        i_reset_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        checkOutput("preset_bus_error", {31'd0, o_bus_error}, 32'd1);
        checkOutput("preset_count", o_pixel_count, 32'd0);
        checkOutput("preset_col_start", {16'd0, o_col_start}, 32'h0000);

        // Hard reset mid-pixel, then a fresh pixel via continue-write
        applyStimulus(1'b0, 8'h2C);
        applyStimulus(1'b1, 8'hAA);
        applyStimulus(1'b1, 8'hBB);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_pixel", {8'd0, o_pixel}, 32'h000000);
        checkOutput("rst_mid_bus_error", {31'd0, o_bus_error}, 32'd0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(posedge clk); #1;
        snap_a = pixel_pulses;
        applyStimulus(1'b0, 8'h3C);
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b1, 8'h03);
        checkOutput("post_rst_pixel", {8'd0, o_pixel}, 32'h010203);
        checkOutput("post_rst_pulses", pixel_pulses - snap_a, 32'd1);
        checkOutput("post_rst_count", o_pixel_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nh_lcd_responder.md
NH_LCD_RESPONDER -- requirements
Module: nh_lcd_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ID_VALUE, 24'h7F8A3C, 3-byte panel ID returned by command 0x04.
- TE_PERIOD, 32'd1000, tearing-effect period in clk cycles (>=2).
- TE_WIDTH, 32'd10, tearing-effect high time in clk cycles (1..TE_PERIOD-1).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_reset_n  in  1  host panel reset, active low, asynchronous to clk.
- i_cs_n  in  1  host chip select, active low.
- i_register_data_sel  in  1  0 = command byte, 1 = parameter/data byte.
- i_write_n  in  1  host write strobe; byte captured on rising edge.
- i_read_n  in  1  host read strobe, active low.
- i_data  in  8  host bus data.
- o_data  out  8  responder read data.
- o_read_en  out  1  responder drives the bus.
- o_tearing_effect  out  1  TE pulse to host.
- o_cmd_stb / o_cmd  out  1/8  one-cycle pulse with the decoded command byte.
- o_param_stb / o_param  out  1/8  one-cycle pulse with a non-pixel parameter byte.
- o_pixel_stb / o_pixel  out  1/24  one-cycle pulse with an assembled RGB pixel.
- o_pixel_count  out  32  pixels received since the last 0x2C.
- o_col_start, o_col_end, o_page_start, o_page_end  out  16 each  address window.
- o_bus_error  out  1  sticky protocol error flag.

Function
REQ-003 All host inputs SHALL pass through 2-FF synchronizers; edges SHALL be detected on the synchronized signals.
REQ-004 A write SHALL be accepted on a synchronized rising edge of i_write_n while synchronized i_cs_n = 0; the byte SHALL be the synchronized i_data in that same cycle.
REQ-005 Write-related strobes SHALL assert exactly 3 clk after i_write_n rises, for 1 cycle.
REQ-006 Command byte: o_cmd_stb SHALL pulse and the FSM SHALL transition from any state, discarding any partial pixel or parameter sequence.
REQ-007 FSM states are IDLE, MEM_WRITE, COL_ADDR, PAGE_ADDR, READ_ID.
- 0x2C -> MEM_WRITE, o_pixel_count := 0.
- 0x3C -> MEM_WRITE, o_pixel_count kept.
- 0x2A -> COL_ADDR; 0x2B -> PAGE_ADDR; 0x04 -> READ_ID with read index 0.
- 0x35 sets TE enable; 0x34 clears it; both then go to IDLE.
- Any other command -> IDLE.
REQ-008 MEM_WRITE: data bytes fill o_pixel [23:16], [15:8], [7:0] in order. On the 3rd byte, o_pixel_stb SHALL pulse and o_pixel_count SHALL increment, saturating at 32'hFFFFFFFF; the byte index then wraps to 0.
REQ-009 COL_ADDR/PAGE_ADDR: parameter bytes 1–4 are start[15:8], start[7:0], end[15:8], end[7:0]. Start SHALL update after byte 2 and end after byte 4; further bytes SHALL be ignored. Every byte SHALL pulse o_param_stb.
REQ-010 In IDLE or READ_ID, a data byte SHALL pulse o_param_stb only.
REQ-011 Read: on a synchronized falling edge of i_read_n with cs_n = 0, o_read_en SHALL go to 1 and o_data SHALL be loaded. Both SHALL hold until the synchronized rising edge of i_read_n, when o_read_en = 0 and the read index increments, saturating at 4.
REQ-012 Read data:
- READ_ID: index 0 = 8'h00, 1 = ID_VALUE[23:16], 2 = ID_VALUE[15:8], 3 = ID_VALUE[7:0], >=4 = 8'h00.
- Any other state: 8'h00.
REQ-013 Synchronized i_write_n and i_read_n both low with cs_n = 0 SHALL set o_bus_error; that write and read SHALL be ignored.
REQ-014 TE: while enabled, a free-running counter runs 0..TE_PERIOD-1 and o_tearing_effect = 1 while the count < TE_WIDTH. When disabled, o_tearing_effect = 0 and the counter is 0.
REQ-015 Synchronized i_reset_n = 0 SHALL apply the REQ-016 reset values, except o_bus_error, which is kept.

Reset
REQ-016 rst = 0 SHALL asynchronously clear:
- FSM to IDLE, TE disabled.
- All strobes, o_read_en, o_data, o_pixel, o_pixel_count, address outputs, o_bus_error, counters, byte and read indices = 0.
- Synchronizer stages: i_write_n, i_read_n, i_cs_n = 1; others 0.
REQ-017 Reset mid-pixel or mid-read SHALL discard the partial pixel and release the bus within the same cycle.

Structure
REQ-018 Command opcodes (0x04, 0x2A, 0x2B, 0x2C, 0x34, 0x35, 0x3C) and the FSM state encoding SHALL live in shared package nh_lcd_pkg.
REQ-019 Synchronizer plus edge detection SHALL be sub-module nh_lcd_bus_sync; decode, FSM, read mux and TE stay in nh_lcd_responder.

Verification
REQ-020 Write 0x2C, then data 0x11,0x22,0x33,0x44 -> one o_pixel_stb with 24'h112233, o_pixel_count = 1, no second pixel.
REQ-021 Write 0x2A, then 0x00,0x10,0x01,0x3F -> o_col_start = 16'h0010, o_col_end = 16'h013F, 4 o_param_stb pulses.
REQ-022 Write 0x04, then 5 reads -> 00, 7F, 8A, 3C, 00; o_read_en high only during each read.
REQ-023 Write 0x35 with TE_PERIOD = 20, TE_WIDTH = 3 -> TE high 3 of every 20 cycles; after 0x34 -> TE stays 0.
REQ-024 Drive write_n and read_n low together -> o_bus_error = 1, no strobes; then i_reset_n pulse -> o_bus_error stays 1, o_pixel_count = 0.
REQ-025 rst low after 2 of 3 pixel bytes, then 0x3C plus 3 bytes -> o_pixel = the new bytes, o_pixel_count = 1.
